sm_table_writer: RTL and testbench

SM_TABLE_WRITER -- requirements
Module: sm_table_writer

---
 rtl/sm_table_writer.sv | 135 +++++++++++++
 tb/tb_sm_table_writer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_table_writer.sv
// Walks every {a, b} address and writes the sign-magnitude sum a+b, one beat
// per accepted valid/ready handshake, while keeping a 16-bit running checksum.
module sm_table_writer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH:0]   wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           checksum
);

  localparam int unsigned MAG_W = DATA_WIDTH - 1;
  localparam int unsigned SUM_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_busy;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH:0]   r_data;
  logic [SUM_W-1:0]      r_sum;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [SUM_W-1:0]      w_sum_nxt;
  logic [DATA_WIDTH:0]   w_data_nxt;

  // Sign-magnitude a+b for the operands packed in addr; zero always comes out as +0.
  function automatic logic [DATA_WIDTH:0] sm_add(input logic [ADDR_WIDTH-1:0] addr);
    logic                  sa;
    logic                  sb;
    logic                  sign;
    logic [MAG_W-1:0]      ma;
    logic [MAG_W-1:0]      mb;
    logic [DATA_WIDTH-1:0] mag;
    sa = addr[ADDR_WIDTH-1];
    sb = addr[DATA_WIDTH-1];
    ma = addr[DATA_WIDTH +: MAG_W];
    mb = addr[0 +: MAG_W];
    if (sa == sb) begin
      mag  = DATA_WIDTH'(ma) + DATA_WIDTH'(mb);
      sign = sa;
    end else if (ma >= mb) begin
      mag  = DATA_WIDTH'(ma - mb);
      sign = sa;
    end else begin
      mag  = DATA_WIDTH'(mb - ma);
      sign = sb;
    end
    if (mag == '0) begin
      sign = 1'b0;
    end
    return {sign, mag};
  endfunction

  // Next-state, next-address and next-checksum logic.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_sum_nxt   = r_sum;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_WRITE;
          w_addr_nxt  = '0;
          w_sum_nxt   = '0;
        end
      end
      S_WRITE: begin
        // abort wins over a beat that would otherwise be accepted this cycle
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (wr_ready) begin
          w_addr_nxt = r_addr + ADDR_WIDTH'(1);
          w_sum_nxt  = r_sum + SUM_W'(r_data);
          if (&r_addr) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_data_nxt = sm_add(w_addr_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output registers track the next state so flags line up with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_sum  <= '0;
    end else begin
      r_busy <= (w_state_nxt == S_WRITE);
      r_done <= (w_state_nxt == S_DONE);
      r_addr <= w_addr_nxt;
      r_data <= w_data_nxt;
      r_sum  <= w_sum_nxt;
    end
  end

  assign wr_valid = r_busy;
  assign busy     = r_busy;
  assign done     = r_done;
  assign wr_addr  = r_addr;
  assign wr_data  = r_data;
  assign checksum = r_sum;

endmodule

// File: tb/tb_sm_table_writer.sv
// Bench for sm_table_writer: scoreboarded full run, abort, async reset, and a
// narrow instance exercising random backpressure over its whole table.
module tb_sm_table_writer;

  typedef struct packed {
    logic [15:0] addr;
    logic [8:0]  data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start, abort, wr_ready;
  logic        wr_valid, busy, done;
  logic [15:0] wr_addr;
  logic [8:0]  wr_data;
  logic [15:0] checksum;

  logic        s_start, s_abort, s_ready;
  logic        s_valid, s_busy, s_done;
  logic [7:0]  s_addr;
  logic [4:0]  s_data;
  logic [15:0] s_checksum;

  int    n_checks = 0;
  int    n_errors = 0;
  int    busy_cycles = 0;
  beat_t sb_q[$];
  beat_t sq[$];
  logic        s_stall_pend = 1'b0;
  logic [7:0]  s_hold_addr;
  logic [4:0]  s_hold_data;

  always #5 clk = ~clk;

  sm_table_writer #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .checksum(checksum)
  );

  sm_table_writer #(.DATA_WIDTH(4), .ADDR_WIDTH(8)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort),
    .wr_valid(s_valid), .wr_ready(s_ready), .wr_addr(s_addr),
    .wr_data(s_data), .busy(s_busy), .done(s_done), .checksum(s_checksum)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decode both operands to signed integers, add, re-encode.
  function automatic int sm_val(input int dw, input int x);
    int m;
    m = x & ((1 << (dw - 1)) - 1);
    return (((x >> (dw - 1)) & 1) != 0) ? -m : m;
  endfunction

  function automatic int model_sum(input int dw, input int addr);
    int s;
    s = sm_val(dw, (addr >> dw) & ((1 << dw) - 1)) + sm_val(dw, addr & ((1 << dw) - 1));
    return (s < 0) ? ((1 << dw) | -s) : s;
  endfunction

  function automatic logic [9:0] spot_exp(input logic [15:0] a);
    case (a)
      16'h0503: return {1'b1, 9'h008};
      16'h8503: return {1'b1, 9'h102};
      16'h0385: return {1'b1, 9'h102};
      16'h7F7F: return {1'b1, 9'h0FE};
      16'hFFFF: return {1'b1, 9'h1FE};
      16'h8080: return {1'b1, 9'h000};
      16'h8505: return {1'b1, 9'h000};
      default:  return 10'h000;
    endcase
  endfunction

  // One clock: monitor both instances on the falling edge, return just after the rising edge.
  task automatic tick();
    beat_t      b;
    logic [9:0] sp;
    @(negedge clk);
    if (busy) busy_cycles++;
    check("valid_eq_busy", 32'(wr_valid), 32'(busy));
    if (rst_n && wr_valid && wr_ready && !abort) begin
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        b = sb_q.pop_front();
        check("beat_addr", 32'(wr_addr), 32'(b.addr));
        check("beat_data", 32'(wr_data), 32'(b.data));
      end
      sp = spot_exp(wr_addr);
      if (sp[9]) check("spot_data", 32'(wr_data), 32'(sp[8:0]));
    end
    if (s_stall_pend && s_valid) begin
      check("stall_addr", 32'(s_addr), 32'(s_hold_addr));
      check("stall_data", 32'(s_data), 32'(s_hold_data));
    end
    s_stall_pend = s_valid && !s_ready;
    s_hold_addr  = s_addr;
    s_hold_data  = s_data;
    if (rst_n && s_valid && s_ready) begin
      check("s_nonempty", 32'(sq.size() != 0), 32'd1);
      if (sq.size() != 0) begin
        b = sq.pop_front();
        check("s_addr", 32'(s_addr), 32'(b.addr));
        check("s_data", 32'(s_data), 32'(b.data));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int full_sum;
    int part_sum;
    int small_sum;
    int bc0;
    start = 1'b0; abort = 1'b0; wr_ready = 1'b1;
    s_start = 1'b0; s_abort = 1'b0; s_ready = 1'b1;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_valid", 32'(wr_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(wr_addr), 32'd0);
    check("rst_data", 32'(wr_data), 32'd0);
    check("rst_sum", 32'(checksum), 32'd0);
    check("rst_s_valid", 32'(s_valid), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // abort in IDLE is ignored
    abort = 1'b1;
    tick();
    tick();
    abort = 1'b0;
    check("idle_abort_busy", 32'(busy), 32'd0);
    check("idle_abort_done", 32'(done), 32'd0);

    // Narrow instance: whole table under random backpressure
    small_sum = 0;
    for (int i = 0; i < 256; i++) begin
      sq.push_back('{addr: 16'(i), data: 9'(model_sum(4, i))});
      small_sum += model_sum(4, i);
    end
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    cyc = 0;
    while (!s_done && cyc < 3000) begin
      s_ready = 1'($urandom_range(1, 0));
      tick();
      cyc++;
    end
    s_ready = 1'b1;
    check("small_done", 32'(s_done), 32'd1);
    check("small_busy", 32'(s_busy), 32'd0);
    check("small_sum", 32'(s_checksum), small_sum & 32'hFFFF);
    check("small_sq_empty", 32'(sq.size()), 32'd0);

    // Full run at wr_ready=1, with a stray start mid-run
    full_sum = 0;
    for (int i = 0; i < 65536; i++) begin
      sb_q.push_back('{addr: 16'(i), data: 9'(model_sum(8, i))});
      full_sum += model_sum(8, i);
    end
    bc0 = busy_cycles;
    start = 1'b1;
    tick();
    cyc = 0;
    while (!done && cyc < 70000) begin
      start = (cyc == 100);
      tick();
      cyc++;
    end
    start = 1'b0;
    check("full_done", 32'(done), 32'd1);
    check("full_busy_cycles", 32'(busy_cycles - bc0), 32'd65536);
    check("full_busy_low", 32'(busy), 32'd0);
    check("full_valid_low", 32'(wr_valid), 32'd0);
    check("full_sum", 32'(checksum), full_sum & 32'hFFFF);
    check("full_addr_wrap", 32'(wr_addr), 32'd0);
    check("full_sq_empty", 32'(sb_q.size()), 32'd0);

    // DONE holds, abort ignored
    abort = 1'b1;
    tick();
    tick();
    abort = 1'b0;
    check("done_hold", 32'(done), 32'd1);
    check("done_sum_hold", 32'(checksum), full_sum & 32'hFFFF);
    check("done_addr_hold", 32'(wr_addr), 32'd0);

    // Abort at 0x1234
    part_sum = 0;
    for (int i = 0; i < 16'h1234; i++) begin
      sb_q.push_back('{addr: 16'(i), data: 9'(model_sum(8, i))});
      part_sum += model_sum(8, i);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (wr_addr != 16'h1234 && cyc < 6000) begin
      tick();
      cyc++;
    end
    check("abort_reach", 32'(wr_addr), 32'h1234);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_valid", 32'(wr_valid), 32'd0);
    check("abort_sum", 32'(checksum), part_sum & 32'hFFFF);
    check("abort_sq_empty", 32'(sb_q.size()), 32'd0);
    tick();
    tick();
    check("abort_sum_hold", 32'(checksum), part_sum & 32'hFFFF);

    // Restart from 0, then async reset mid-run
    for (int i = 0; i < 16'h0050; i++) begin
      sb_q.push_back('{addr: 16'(i), data: 9'(model_sum(8, i))});
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (wr_addr != 16'h0050 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("rst_reach", 32'(wr_addr), 32'h0050);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(wr_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_addr", 32'(wr_addr), 32'd0);
    check("arst_data", 32'(wr_data), 32'd0);
    check("arst_sum", 32'(checksum), 32'd0);
    check("arst_small_done", 32'(s_done), 32'd0);
    check("arst_sq_empty", 32'(sb_q.size()), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // After reset a new start regenerates from address 0
    for (int i = 0; i < 16; i++) begin
      sb_q.push_back('{addr: 16'(i), data: 9'(model_sum(8, i))});
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (wr_addr != 16'h0010 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("post_rst_reach", 32'(wr_addr), 32'h0010);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_sq_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
